// File: rtl/seq_priority_encoder.sv
// Registered N-to-log2(N) request encoder with fixed-priority or round-robin issue over valid/ready.
// Optional out_onehot output enabled by defining SEQ_PRIO_ENC_ONEHOT_EN.
module seq_priority_encoder #(
  parameter int unsigned N = 8,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
`ifdef SEQ_PRIO_ENC_ONEHOT_EN
  output logic [N-1:0]     out_onehot,
`endif
  output logic [N-1:0]     pending
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] rr_ptr, ptr_next;
  logic [IDX_W-1:0] idx_next, fix_idx, rr_idx, rr_k, sel_idx;
  logic [N-1:0]     pending_next, clr;
  logic             valid_next, sel_en, rr_found;

  // Candidate indices: highest set bit, and first set bit after rr_ptr (wrapping).
  always_comb begin
    fix_idx  = '0;
    rr_idx   = '0;
    rr_k     = '0;
    rr_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pending[i]) fix_idx = IDX_W'(i);
    end
    for (int unsigned j = 1; j <= N; j++) begin
      rr_k = IDX_W'((32'(rr_ptr) + j) % N);
      if (!rr_found && pending[rr_k]) begin
        rr_found = 1'b1;
        rr_idx   = rr_k;
      end
    end
  end

  assign sel_idx = mode ? rr_idx : fix_idx;

  // Next-state and registered-output values.
  always_comb begin
    state_next = state;
    valid_next = out_valid;
    idx_next   = out_idx;
    ptr_next   = rr_ptr;
    sel_en     = 1'b0;
    clr        = '0;
    case (state)
      IDLE: begin
        if (|pending) begin
          sel_en     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (|pending) begin
            sel_en = 1'b1;
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (sel_en) begin
      valid_next = 1'b1;
      idx_next   = sel_idx;
      ptr_next   = sel_idx;
      clr        = N'(1) << sel_idx;
    end
    // A request arriving on the grant cycle re-arms the bit.
    pending_next = (pending & ~clr) | req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      rr_ptr    <= IDX_W'(N - 1);
      pending   <= '0;
    end else begin
      state     <= state_next;
      out_valid <= valid_next;
      out_idx   <= idx_next;
      rr_ptr    <= ptr_next;
      pending   <= pending_next;
    end
  end

`ifdef SEQ_PRIO_ENC_ONEHOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_onehot <= '0;
    else        out_onehot <= valid_next ? (N'(1) << idx_next) : '0;
  end
`endif

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Self-checking bench for seq_priority_encoder (N=8): directed table, hand sequences, random vs model.
module tb_seq_priority_encoder;

  localparam int unsigned N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       mode;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] pending;
`ifdef SEQ_PRIO_ENC_ONEHOT_EN
  logic [7:0] out_onehot;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  seq_priority_encoder #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .out_ready(out_ready),
    .out_valid(out_valid), .out_idx(out_idx),
`ifdef SEQ_PRIO_ENC_ONEHOT_EN
    .out_onehot(out_onehot),
`endif
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       mode;
    logic       rdy;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic [7:0] exp_pend;
  } vec_t;

  vec_t tbl[12];

  // Reference model state.
  bit [7:0] m_pend;
  bit       m_valid;
  int       m_idx;
  int       m_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    m_pend = '0; m_valid = 1'b0; m_idx = 0; m_ptr = N - 1;
  endtask

  // One cycle of the consumer-visible behaviour, from the encoder's stated rules.
  task automatic model_step(input bit [7:0] r, input bit md, input bit rdy);
    int sel;
    sel = -1;
    if ((!m_valid || rdy) && m_pend != 0) begin
      if (!md) begin
        for (int k = N - 1; k >= 0; k--)
          if (sel < 0 && m_pend[k]) sel = k;
      end else begin
        for (int j = 1; j <= N; j++)
          if (sel < 0 && m_pend[(m_ptr + j) % N]) sel = (m_ptr + j) % N;
      end
    end
    if (sel >= 0) begin
      m_pend[sel] = 1'b0;
      m_valid = 1'b1;
      m_idx = sel;
      m_ptr = sel;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_pend = m_pend | r;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; mode = 1'b0; out_ready = 1'b1;
    #2;
    check("reset_valid_async", 64'(out_valid), 64'd0);
    check("reset_pend_async", 64'(pending), 64'd0);
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("idle_valid", 64'(out_valid), 64'd0);
      check("idle_pend", 64'(pending), 64'd0);
      check("idle_idx", 64'(out_idx), 64'd0);
    end

    // Fixed-priority pulse 8'h84 then backpressure pulse 8'h03.
    tbl[0]  = '{8'h84, 1'b0, 1'b1, 1'b0, 3'd0, 8'h84};
    tbl[1]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 8'h04};
    tbl[2]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h00};
    tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00};
    tbl[4]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00};
    tbl[5]  = '{8'h03, 1'b0, 1'b0, 1'b0, 3'd2, 8'h03};
    tbl[6]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h01};
    tbl[7]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h01};
    tbl[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h01};
    tbl[9]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h01};
    tbl[10] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00};
    tbl[11] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req; mode = tbl[i].mode; out_ready = tbl[i].rdy;
      cyc();
      check($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_idx", i), 64'(out_idx), 64'(tbl[i].exp_idx));
      check($sformatf("tbl%0d_pend", i), 64'(pending), 64'(tbl[i].exp_pend));
    end

    // Round-robin with all requests held: 0..7 then wrap to 0,1.
    do_reset();
    mode = 1'b1; out_ready = 1'b1; req = 8'hFF;
    cyc();
    check("rr_pend", 64'(pending), 64'hFF);
    check("rr_first_valid", 64'(out_valid), 64'd0);
    for (int c = 0; c < 10; c++) begin
      cyc();
      check($sformatf("rr%0d_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("rr%0d_idx", c), 64'(out_idx), 64'(c % 8));
    end
    req = '0;

    // Set beats clear on index 5.
    do_reset();
    mode = 1'b0; out_ready = 1'b1; req = 8'h20;
    cyc();
    check("sbc_pend0", 64'(pending), 64'h20);
    cyc();
    check("sbc_valid1", 64'(out_valid), 64'd1);
    check("sbc_idx1", 64'(out_idx), 64'd5);
    check("sbc_pend1", 64'(pending), 64'h20);
    req = '0;
    cyc();
    check("sbc_valid2", 64'(out_valid), 64'd1);
    check("sbc_idx2", 64'(out_idx), 64'd5);
    check("sbc_pend2", 64'(pending), 64'h00);
    cyc();
    check("sbc_valid3", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-burst.
    do_reset();
    mode = 1'b1; out_ready = 1'b0; req = 8'h3C;
    cyc();
    cyc();
    check("mid_pend", 64'(pending), 64'h3C);
    check("mid_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_pend", 64'(pending), 64'd0);
    check("mid_rst_idx", 64'(out_idx), 64'd0);
    cyc();
    check("rst_held_pend", 64'(pending), 64'd0);
    req = '0; out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("post_rst_valid", 64'(out_valid), 64'd0);
      check("post_rst_pend", 64'(pending), 64'd0);
    end

    // Randomized traffic against the model.
    do_reset();
    mode = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      req = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      out_ready = ($urandom_range(0, 3) != 0);
      model_step(req, mode, out_ready);
      cyc();
      check("rnd_valid", 64'(out_valid), 64'(m_valid));
      check("rnd_pend", 64'(pending), 64'(m_pend));
      if (m_valid) check("rnd_idx", 64'(out_idx), 64'(m_idx));
`ifdef SEQ_PRIO_ENC_ONEHOT_EN
      check("rnd_onehot", 64'(out_onehot), m_valid ? (64'd1 << m_idx) : 64'd0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
